// File: rtl/imm_encoder_pkg.sv
// Shared types and constants for the RV32I immediate encoder.
// The IMM_RANGE_CHECK_EN build option is consumed by imm_pack and imm_encoder.
package imm_encoder_pkg;

    typedef enum logic [1:0] {
        IMM_I_S = 2'b00,
        IMM_U   = 2'b01,
        IMM_B   = 2'b10,
        IMM_J   = 2'b11
    } imm_src_e;

    typedef enum logic [2:0] {
        KIND_I,
        KIND_S,
        KIND_U,
        KIND_B,
        KIND_J,
        KIND_R
    } kind_e;

    localparam logic [2:0] OPC_STORE_654 = 3'b010;
    localparam logic [6:0] OPC_RTYPE     = 7'b0110011;
    localparam int         CNT_W         = 16;

    typedef struct packed {
        logic [31:0] word;
        logic [6:0]  funct7;
        kind_e       kind;
        logic        err;
    } s1_payload_t;

    // True when imm[31:lsb] are all ones or all zeros.
    function automatic logic upper_uniform(input logic [31:0] imm, input int lsb);
        logic [31:0] mask;
        mask = 32'hFFFF_FFFF << lsb;
        return ((imm & mask) == mask) || ((imm & mask) == 32'h0);
    endfunction

endpackage

// File: rtl/imm_encoder_if.sv
// Request and delivery channels of the immediate encoder.
// master drives requests and accepts words; slave is the encoder side.
interface imm_encoder_if;

    logic        in_valid;
    logic        in_ready;
    logic [1:0]  in_imm_src;
    logic [6:0]  in_opcode;
    logic [4:0]  in_rd;
    logic [2:0]  in_funct3;
    logic [4:0]  in_rs1;
    logic [4:0]  in_rs2;
    logic [6:0]  in_funct7;
    logic [31:0] in_imm;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic        out_err;

    modport master (
        output in_valid, in_imm_src, in_opcode, in_rd, in_funct3,
               in_rs1, in_rs2, in_funct7, in_imm, out_ready,
        input  in_ready, out_valid, out_instr, out_err
    );

    modport slave (
        input  in_valid, in_imm_src, in_opcode, in_rd, in_funct3,
               in_rs1, in_rs2, in_funct7, in_imm, out_ready,
        output in_ready, out_valid, out_instr, out_err
    );

endinterface

// File: rtl/imm_encoder_pack.sv
// Combinational field scatter and immediate range check for one request.
// Range checking exists only when IMM_RANGE_CHECK_EN is defined.
module imm_pack
    import imm_encoder_pkg::*;
(
    input  logic [1:0]  imm_src,
    input  logic [6:0]  opcode,
    input  logic [4:0]  rd,
    input  logic [2:0]  funct3,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    input  logic [31:0] imm,
    output logic [31:0] word,
    output kind_e       kind,
    output logic        err
);

    always_comb begin
        kind = KIND_I;
        if (opcode == OPC_RTYPE) begin
            kind = KIND_R;
        end else begin
            case (imm_src_e'(imm_src))
                IMM_I_S: kind = (opcode[6:4] == OPC_STORE_654) ? KIND_S : KIND_I;
                IMM_U:   kind = KIND_U;
                IMM_B:   kind = KIND_B;
                IMM_J:   kind = KIND_J;
                default: kind = KIND_I;
            endcase
        end
    end

    // R-type leaves word[31:25] clear; funct7 is merged after stage 1.
    always_comb begin
        word = 32'h0;
        case (kind)
            KIND_I:  word = {imm[11:0], rs1, funct3, rd, opcode};
            KIND_S:  word = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
            KIND_U:  word = {imm[31:12], rd, opcode};
            KIND_B:  word = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
            KIND_J:  word = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
            default: word = {7'b0, rs2, rs1, funct3, rd, opcode};
        endcase
    end

`ifdef IMM_RANGE_CHECK_EN
    always_comb begin
        err = 1'b0;
        case (kind)
            KIND_I, KIND_S: err = !upper_uniform(imm, 11);
            KIND_U:         err = |imm[11:0];
            KIND_B:         err = !upper_uniform(imm, 12) || imm[0];
            KIND_J:         err = !upper_uniform(imm, 20) || imm[0];
            default:        err = 1'b0;
        endcase
    end
`else
    assign err = 1'b0;
`endif

endmodule

// File: rtl/imm_encoder.sv
// RV32I instruction word builder: 2-stage backpressured pipeline plus delivery counters.
// IMM_RANGE_CHECK_EN enables out_err and err_count; otherwise both are tied 0.
module imm_encoder
    import imm_encoder_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    imm_encoder_if.slave     bus,
    output logic [CNT_W-1:0] enc_count,
    output logic [CNT_W-1:0] err_count
);

    logic [31:0] pk_word;
    kind_e       pk_kind;
    logic        pk_err;
    s1_payload_t s1_q;
    logic        s1_valid;
    logic        s2_valid;
    logic [31:0] s2_word;
    logic        s2_err;
    logic [31:0] s1_final;
    logic        s2_free;
    logic        s1_free;
    logic        deliver;

    imm_pack u_pack (
        .imm_src (bus.in_imm_src),
        .opcode  (bus.in_opcode),
        .rd      (bus.in_rd),
        .funct3  (bus.in_funct3),
        .rs1     (bus.in_rs1),
        .rs2     (bus.in_rs2),
        .imm     (bus.in_imm),
        .word    (pk_word),
        .kind    (pk_kind),
        .err     (pk_err)
    );

    assign s2_free      = !s2_valid || bus.out_ready;
    assign s1_free      = !s1_valid || s2_free;
    assign bus.in_ready = s1_free;
    assign deliver      = s2_valid && bus.out_ready;

    assign s1_final = (s1_q.kind == KIND_R) ? (s1_q.word | {s1_q.funct7, 25'd0}) : s1_q.word;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_q     <= '0;
        end else if (s1_free) begin
            s1_valid <= bus.in_valid;
            if (bus.in_valid) begin
                s1_q <= '{word: pk_word, funct7: bus.in_funct7, kind: pk_kind, err: pk_err};
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid <= 1'b0;
            s2_word  <= 32'h0;
            s2_err   <= 1'b0;
        end else if (s2_free) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_word <= s1_final;
                s2_err  <= s1_q.err;
            end
        end
    end

    assign bus.out_valid = s2_valid;
    assign bus.out_instr = s2_word;
    assign bus.out_err   = s2_err;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            enc_count <= '0;
        end else if (deliver && (enc_count != '1)) begin
            enc_count <= enc_count + CNT_W'(1);
        end
    end

`ifdef IMM_RANGE_CHECK_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_count <= '0;
        end else if (deliver && s2_err && (err_count != '1)) begin
            err_count <= err_count + CNT_W'(1);
        end
    end
`else
    assign err_count = '0;
`endif

endmodule

// File: doc/imm_encoder.md
# imm_encoder

Packs an operation's fields and a 32-bit immediate into a complete RV32I instruction word, scattering the immediate into the bit positions the core's immediate sign-extender gathers from. Accepts requests over a valid/ready handshake and delivers words through a 2-stage backpressured pipeline. Sits in the instruction-generation path: boot/test stimulus generator and self-modifying-code test harness feeding instruction memory. For every in-range request, decoding the produced word returns the original immediate.

## Interface
- No parameters. The counter width is fixed at 16.
- clk  in  1  single clock domain; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  request present.
- in_ready  out  1  request accepted this cycle when in_valid && in_ready.
- in_imm_src  in  2  00 I/S (S when in_opcode[6:4]==3'b010), 01 U, 10 B, 11 J.
- in_opcode  in  7  placed at word[6:0].
- in_rd  in  5  placed at word[11:7] for I/U/J; ignored for S/B.
- in_funct3  in  3  placed at word[14:12] for I/S/B; ignored for U/J.
- in_rs1  in  5  placed at word[19:15] for I/S/B; ignored for U/J.
- in_rs2  in  5  placed at word[24:20] for S/B; ignored otherwise.
- in_funct7  in  7  placed at word[31:25] for a non-immediate word when in_imm_src==00 is not used; this block always overwrites it with immediate bits, and the port exists only for R-type pass-through when in_opcode==7'b0110011. In that case no immediate is inserted and no error is raised.
- in_imm  in  32  immediate, two's complement.
- out_valid  out  1  word available.
- out_ready  in  1  downstream accepts.
- out_instr  out  32  encoded instruction.
- out_err  out  1  immediate not representable; word still emitted.
- enc_count  out  16  words delivered, saturating.
- err_count  out  16  erroneous words delivered, saturating.

## Operation
- Bit mapping by type:
  - I: word[31:20] = imm[11:0].
  - S: word[31:25] = imm[11:5], word[11:7] = imm[4:0].
  - U: word[31:12] = imm[31:12].
  - B: word[31] = imm[12], word[7] = imm[11], word[30:25] = imm[10:5], word[11:8] = imm[4:1].
  - J: word[31] = imm[20], word[30:21] = imm[10:1], word[20] = imm[11], word[19:12] = imm[19:12].
- Range rules (out_err=1 if violated):
  - I/S: imm[31:11] all equal.
  - U: imm[11:0]==0.
  - B: imm[31:12] all equal, and imm[0]==0.
  - J: imm[31:20] all equal, and imm[0]==0.
- On violation the word uses the truncated bits exactly as mapped.
- Stage 1 registers the packed fields, the type, and the error flag. Stage 2 registers the final word and out_err.
- Counters increment on output handshake only. err_count increments when out_err is also 1. Both saturate at 16'hFFFF.

## Timing
- Reset values: out_valid=0, out_instr=0, out_err=0, both counters 0, stage-1 valid=0.
- in_ready is 1 from the first cycle after reset.
- Latency: a request accepted in cycle N appears with out_valid=1 in cycle N+2 when there is no backpressure.
- Throughput: 1 word per cycle. in_ready = !s1_valid || (!s2_valid || out_ready), evaluated combinationally.
- Stall: while out_valid && !out_ready, out_instr and out_err hold stable. Stage 1 holds if full. in_ready drops only when both stages are full.
- Simultaneous handshakes: accepting a new request while delivering a word moves both stages in the same cycle; no bubble and no loss.
- Reset mid-operation discards in-flight words; counters clear.
- Assertion of in_valid with in_ready low: the request is held by the sender and not sampled.

## Configuration
- IMM_RANGE_CHECK_EN defined: range rules are evaluated, out_err is driven, and err_count is implemented.
- IMM_RANGE_CHECK_EN undefined: no checking logic, out_err tied 0, err_count tied 0. Packing and timing are identical.

## Structure
- Shared package holds:
  - imm_src encodings (IMM_I_S=2'b00, IMM_U, IMM_B, IMM_J).
  - OPC_STORE_654=3'b010.
  - OPC_RTYPE=7'b0110011.
  - A packed struct for the stage-1 payload.
- One sub-module, imm_pack: purely combinational field scatter plus range check; instantiated in stage 1. Pipeline, handshake, and counters are in the top.

## Test plan
- I addi: opcode 0010011, rd=1, f3=0, rs1=0, imm=32'hFFFFFFFF, src=00. Expect out_instr=32'hFFF00093, out_err=0, 2 cycles after accept.
- S sw: opcode 0100011, f3=010, rs1=1, rs2=2, imm=8, src=00. Expect 32'h0020A423.
- U lui: opcode 0110111, rd=5, imm=32'h12345000, src=01. Expect 32'h123452B7. Then imm=32'h12345001, expect out_err=1 and err_count=1.
- B/J: beq x0,x0 with imm=-4 (src=10) expects 32'hFE000EE3. jal rd=1 with imm=2048 (src=11) expects 32'h001000EF. Odd imm=3 with src=10 expects out_err=1.
- Backpressure: stream 4 back-to-back requests with out_ready low for 3 cycles. in_ready falls after 2 accepts; all 4 words emerge in order and unchanged; enc_count=4.
- Reset mid-stream: assert rst_n=0 with both stages full. out_valid=0 immediately, counters=0. The first post-reset request produces a word 2 cycles after its accept.
